// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : UART receiver. It takes an 11-bit frame on a single wire and
//             returns the 8-bit byte. The frame is a start bit (0), 8 data
//             bits LSB first, a parity bit and a stop bit (1). Each bit is
//             sampled at mid-bit using a clock-cycle bit timer.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             onebit_data  - serial line, idle high, asynchronous to clk
//             data_out     - last received byte (held until next strobe)
//             data_valid   - one-cycle strobe: data_out and flags updated
//             parity_err   - received parity differs from expected
//             frame_err    - stop bit sampled low
//             busy         - receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,  // must be >= 4
  parameter bit PARITY_ODD   = 1'b0   // 0: even parity, 1: odd parity
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       onebit_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // START samples half a bit in, which places every later sample at mid-bit.
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic          sync1_q, rx_s_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_par_q, rx_par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  // The synchronizer resets to 1 so that leaving reset with the line idle
  // does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      rx_par_q <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= onebit_data;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rx_par_q <= rx_par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    rx_par_d = rx_par_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            // The line went high again: a glitch. Flags are left unchanged.
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d         = '0;
          shift_d[idx_q]  = rx_s_q;
          if (idx_q == 3'd7) state_d = S_PARITY;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d  = '0;
          rx_par_d = rx_s_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          data_d  = shift_q;
          perr_d  = rx_par_q != ((^shift_q) ^ PARITY_ODD);
          ferr_d  = !rx_s_q;
          valid_d = 1'b1;
          // If the line is still low it is a break. Wait for it to go high so
          // that the held-low line does not start a new frame.
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver. Two instances share one
//             serial line: one checks even parity and one checks odd parity.
//             The bench keeps a queue of the frames it sent. For each frame it
//             stores the byte and the flags it expects. On every cycle the
//             outputs of both instances are compared with that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [7:0] do0, do1;
  logic       dv0, dv1, pe0, pe1, fe0, fe1, bz0, bz1;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .onebit_data(line),
    .data_out(do0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(bz0)
  );

  uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .onebit_data(line),
    .data_out(do1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(bz1)
  );

  typedef struct {
    logic [7:0] d;
    logic       p0;  // expected parity_err, even instance
    logic       p1;  // expected parity_err, odd instance
    logic       f;   // expected frame_err
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] exp_data = 8'h00;
  logic       exp_p0 = 1'b0, exp_p1 = 1'b0, exp_f = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_data = 8'h00;
    exp_p0   = 1'b0;
    exp_p1   = 1'b0;
    exp_f    = 1'b0;
  endtask

  // Both instances must strobe together. Each strobe takes the oldest
  // expected frame from the queue. Between strobes the outputs must hold.
  always @(negedge clk) begin
    chk("valid_agree", 32'(dv1), 32'(dv0));
    if (dv0) begin
      if (q.size() == 0) chk("unexpected_strobe", 32'(dv0), 32'd0);
      else begin
        e        = q.pop_front();
        exp_data = e.d;
        exp_p0   = e.p0;
        exp_p1   = e.p1;
        exp_f    = e.f;
      end
    end
    chk("data_even",  32'(do0), 32'(exp_data));
    chk("data_odd",   32'(do1), 32'(exp_data));
    chk("perr_even",  32'(pe0), 32'(exp_p0));
    chk("perr_odd",   32'(pe1), 32'(exp_p1));
    chk("ferr_even",  32'(fe0), 32'(exp_f));
    chk("ferr_odd",   32'(fe1), 32'(exp_f));
  end

  task automatic drive_bit(input logic v);
    line = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Call this at a negedge. It returns at the negedge after the stop bit. By
  // then the strobe for this frame (at stop mid-bit) must have been seen.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t x;
    x.d  = d;
    x.p0 = (par != (^d));
    x.p1 = (par != ~(^d));
    x.f  = ~stop;
    q.push_back(x);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    chk("strobe_seen", 32'(q.size()), 32'd0);
    if (q.size() != 0) q.delete();
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data",  32'(do0), 32'h00);
    chk("rst_valid", 32'(dv0), 32'd0);
    chk("rst_perr",  32'(pe0), 32'd0);
    chk("rst_ferr",  32'(fe0), 32'd0);
    chk("rst_busy",  32'(bz0), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(4);

    // Good frame.
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_data", 32'(do0), 32'hA5);
    chk("a5_perr", 32'(pe0), 32'd0);
    chk("a5_ferr", 32'(fe0), 32'd0);
    chk("a5_busy", 32'(bz0), 32'd0);
    idle(3);

    // Parity error, then the flag clears on the next good frame.
    send_frame(8'h01, 1'b0, 1'b1);
    chk("01_data", 32'(do0), 32'h01);
    chk("01_perr", 32'(pe0), 32'd1);
    idle(2);
    send_frame(8'h03, 1'b0, 1'b1);
    chk("03_perr", 32'(pe0), 32'd0);
    idle(2);

    // Stop bit low, then the line is held low (break).
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_ferr", 32'(fe0), 32'd1);
    repeat (40) @(negedge clk);
    chk("break_busy_even", 32'(bz0), 32'd1);
    chk("break_busy_odd",  32'(bz1), 32'd1);
    idle(4);
    chk("break_end_busy", 32'(bz0), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1);
    chk("55_ferr", 32'(fe0), 32'd0);
    idle(3);

    // 2-cycle glitch on an idle line.
    line = 1'b0;
    repeat (2) @(negedge clk);
    line = 1'b1;
    repeat (CPB / 2 + 1) @(negedge clk);
    chk("glitch_busy", 32'(bz0), 32'd0);
    chk("glitch_data", 32'(do0), 32'h55);
    idle(CPB);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    chk("b2b_data", 32'(do0), 32'h80);
    chk("b2b_perr", 32'(pe0), 32'd0);
    idle(3);

    // Reset asserted during data bit 4 of 0x5A.
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    line = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_data",  32'(do0), 32'h00);
    chk("mid_rst_busy",  32'(bz0), 32'd0);
    chk("mid_rst_valid", 32'(dv0), 32'd0);
    chk("mid_rst_perr",  32'(pe0), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(12 * CPB);
    send_frame(8'h81, 1'b0, 1'b1);
    chk("81_even_data", 32'(do0), 32'h81);
    chk("81_even_perr", 32'(pe0), 32'd0);
    idle(2);
    send_frame(8'h81, 1'b1, 1'b1);
    chk("81_odd_perr", 32'(pe1), 32'd0);
    idle(2);

    // Random frames, with occasional bad parity or bad stop bits and random gaps.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       par, stop;
      d    = 8'($urandom);
      par  = (^d) ^ ($urandom_range(3) == 0);
      stop = ($urandom_range(4) != 0);
      send_frame(d, par, stop);
      if (!stop) begin
        repeat ($urandom_range(20)) @(negedge clk);
        idle($urandom_range(CPB, 3));
      end else begin
        idle($urandom_range(12));
      end
    end

    idle(2 * CPB);
    chk("final_queue", 32'(q.size()), 32'd0);
    chk("final_busy",  32'(bz0 | bz1), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
